// File: rtl/data_mem_ctrl.sv
// Byte-addressable RV32I data memory with a valid/ready request port and a fixed-latency response.
// Optional macro DMEM_PRELOAD_EN preloads words 0..4 with 17, 9, 25, 30, 12 (all other words 0).
module data_mem_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // state | meaning
  // IDLE  | ready for a request, no response pending
  // WAIT  | request held, latency counter running, not ready
  // RESP  | response pulse this cycle, ready for a back-to-back request
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic              accept;
  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic [1:0]        lane;
  logic              range_err, func_err, align_err, err;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_val;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready  = (state != WAIT);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign accept     = req_valid & req_ready;

  assign word_idx = req_addr[ADDR_W-1:2];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign lane     = req_addr[1:0];

  // The range check only exists when the address space is larger than the array.
  generate
    if (DEPTH_WORDS < (1 << (ADDR_W-2))) begin : g_range
      localparam logic [ADDR_W-3:0] LIM = DEPTH_WORDS[ADDR_W-3:0];
      assign range_err = (word_idx >= LIM);
    end else begin : g_full
      assign range_err = 1'b0;
    end
  endgenerate

  always_comb begin
    func_err = 1'b0;
    if (req_we) begin
      func_err = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010);
    end else begin
      func_err = (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
    end
    align_err = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (lane != 2'b00));
    err = func_err | align_err | range_err;
  end

  always_comb begin
    be = 4'b1111;
    wd = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be = req_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = req_wdata;
      end
    endcase
  end

  always_comb begin
    rd_word  = mem[mem_idx];
    rd_byte  = rd_word[{lane, 3'b000} +: 8];
    rd_half  = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = 32'd0;
    case (req_funct3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'd0, rd_byte};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = 32'd0;
    endcase
  end

`ifdef DMEM_PRELOAD_EN
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    mem[0] <= 32'd17;
    mem[1] <= 32'd9;
    mem[2] <= 32'd25;
    mem[3] <= 32'd30;
    mem[4] <= 32'd12;
  end
`else
`endif

  // The array is never reset; a store commits on its acceptance edge.
  always @(posedge clk) begin
    if (!rst && accept && req_we && !err) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[mem_idx][8*k +: 8] <= wd[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= (err || req_we) ? 32'd0 : load_val;
      err_q   <= err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, RESP: begin
        state_nxt = IDLE;
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 2'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 2'd1;
        if (cnt == 2'd1) state_nxt = RESP;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a LATENCY=1 / ADDR_W=10 instance and a LATENCY=3 instance.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst1, v1, we1, rdy1, rv1, e1;
  logic [2:0]  f1;
  logic [9:0]  a1;
  logic [31:0] wd1, rd1;

  logic        rst3, v3, we3, rdy3, rv3, e3;
  logic [2:0]  f3;
  logic [7:0]  a3;
  logic [31:0] wd3, rd3;

  logic [32:0] q1[$];
  logic [32:0] q3[$];
  string       n1[$];
  string       n3[$];

  data_mem_ctrl #(.ADDR_W(10), .DEPTH_WORDS(64), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst1), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_funct3(f1), .req_addr(a1), .req_wdata(wd1),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(e1)
  );

  data_mem_ctrl #(.ADDR_W(8), .DEPTH_WORDS(64), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst3), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
    .req_funct3(f3), .req_addr(a3), .req_wdata(wd3),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(e3)
  );

  // One clock step; any response present afterwards is scored against the queue.
  task automatic tick();
    logic [32:0] e;
    string nm;
    @(posedge clk);
    #1;
    if (rv1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL u1_unexpected_resp got err=%b rdata=%h required no response", e1, rd1);
      end else begin
        e  = q1.pop_front();
        nm = n1.pop_front();
        if ({e1, rd1} !== e) begin
          errors++;
          $display("FAIL %s got err=%b rdata=%h required err=%b rdata=%h", nm, e1, rd1, e[32], e[31:0]);
        end
      end
    end
    if (rv3) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL u3_unexpected_resp got err=%b rdata=%h required no response", e3, rd3);
      end else begin
        e  = q3.pop_front();
        nm = n3.pop_front();
        if ({e3, rd3} !== e) begin
          errors++;
          $display("FAIL %s got err=%b rdata=%h required err=%b rdata=%h", nm, e3, rd3, e[32], e[31:0]);
        end
      end
    end
  endtask

  task automatic req1(input string nm, input logic we, input logic [2:0] fn, input logic [9:0] addr,
                      input logic [31:0] wdata, input logic [31:0] erd, input logic eerr);
    int n = 0;
    v1 = 1'b1; we1 = we; f1 = fn; a1 = addr; wd1 = wdata;
    while (!rdy1 && n < 20) begin tick(); n++; end
    if (n == 20) begin
      checks++; errors++;
      $display("FAIL %s_ready_timeout got ready=0 required ready=1", nm);
    end
    q1.push_back({eerr, erd});
    n1.push_back(nm);
    tick();
    v1 = 1'b0;
  endtask

  task automatic req3(input string nm, input logic we, input logic [2:0] fn, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic [31:0] erd, input logic eerr);
    int n = 0;
    v3 = 1'b1; we3 = we; f3 = fn; a3 = addr; wd3 = wdata;
    while (!rdy3 && n < 20) begin tick(); n++; end
    if (n == 20) begin
      checks++; errors++;
      $display("FAIL %s_ready_timeout got ready=0 required ready=1", nm);
    end
    q3.push_back({eerr, erd});
    n3.push_back(nm);
    tick();
    v3 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && (q1.size() != 0 || q3.size() != 0); i++) tick();
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got pending u1=%0d u3=%0d required 0", q1.size(), q3.size());
    end
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1;
    v1 = 1'b0; we1 = 1'b0; f1 = 3'b010; a1 = '0; wd1 = '0;
    v3 = 1'b0; we3 = 1'b0; f3 = 3'b010; a3 = '0; wd3 = '0;
    tick(); tick();
    checks++;
    if ({rdy1, rv1, e1, rd1} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_u1 got ready=%b valid=%b err=%b rdata=%h required 1 0 0 00000000", rdy1, rv1, e1, rd1);
    end
    checks++;
    if ({rdy3, rv3, e3, rd3} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_u3 got ready=%b valid=%b err=%b rdata=%h required 1 0 0 00000000", rdy3, rv3, e3, rd3);
    end
    rst1 = 1'b0; rst3 = 1'b0;
    tick();
  endtask

  task automatic test_first_load();
`ifdef DMEM_PRELOAD_EN
    req1("lw_preload_08", 1'b0, 3'b010, 10'h008, 32'h0, 32'd25, 1'b0);
    checks++;
    if (rv1 !== 1'b1) begin
      errors++;
      $display("FAIL lw_latency1 got valid=%b required valid=1", rv1);
    end
`else
    req1("sw_08", 1'b1, 3'b010, 10'h008, 32'd25, 32'h0, 1'b0);
    req1("lw_08", 1'b0, 3'b010, 10'h008, 32'h0, 32'd25, 1'b0);
`endif
    drain();
  endtask

  task automatic test_load_ext();
    req1("sw_10",   1'b1, 3'b010, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0);
    req1("lb_13",   1'b0, 3'b000, 10'h013, 32'h0, 32'hFFFFFFDE, 1'b0);
    req1("lbu_13",  1'b0, 3'b100, 10'h013, 32'h0, 32'h000000DE, 1'b0);
    req1("lh_12",   1'b0, 3'b001, 10'h012, 32'h0, 32'hFFFFDEAD, 1'b0);
    req1("lhu_10",  1'b0, 3'b101, 10'h010, 32'h0, 32'h0000BEEF, 1'b0);
    req1("lb_10",   1'b0, 3'b000, 10'h010, 32'h0, 32'hFFFFFFEF, 1'b0);
    req1("lbu_11",  1'b0, 3'b100, 10'h011, 32'h0, 32'h000000BE, 1'b0);
    req1("lw_10",   1'b0, 3'b010, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0);
    drain();
  endtask

  task automatic test_sub_word_store();
    req1("sb_11",    1'b1, 3'b000, 10'h011, 32'hFFFFFF5A, 32'h0, 1'b0);
    req1("lw_10_sb", 1'b0, 3'b010, 10'h010, 32'h0, 32'hDEAD5AEF, 1'b0);
    req1("sh_12",    1'b1, 3'b001, 10'h012, 32'hAAAA1234, 32'h0, 1'b0);
    req1("lw_10_sh", 1'b0, 3'b010, 10'h010, 32'h0, 32'h12345AEF, 1'b0);
    drain();
  endtask

  task automatic test_errors();
    req1("sw_04",        1'b1, 3'b010, 10'h004, 32'hCAFEF00D, 32'h0, 1'b0);
    req1("sw_00",        1'b1, 3'b010, 10'h000, 32'h01020304, 32'h0, 1'b0);
    req1("sw_fc",        1'b1, 3'b010, 10'h0FC, 32'h00000077, 32'h0, 1'b0);
    req1("err_lh_05",    1'b0, 3'b001, 10'h005, 32'h0, 32'h0, 1'b1);
    req1("err_lh_13",    1'b0, 3'b001, 10'h013, 32'h0, 32'h0, 1'b1);
    req1("err_sw_06",    1'b1, 3'b010, 10'h006, 32'hFFFFFFFF, 32'h0, 1'b1);
    req1("err_lw_100",   1'b0, 3'b010, 10'h100, 32'h0, 32'h0, 1'b1);
    req1("err_sw_100",   1'b1, 3'b010, 10'h100, 32'hFFFFFFFF, 32'h0, 1'b1);
    req1("err_st_f011",  1'b1, 3'b011, 10'h004, 32'hFFFFFFFF, 32'h0, 1'b1);
    req1("err_st_f100",  1'b1, 3'b100, 10'h004, 32'hFFFFFFFF, 32'h0, 1'b1);
    req1("err_ld_f110",  1'b0, 3'b110, 10'h004, 32'h0, 32'h0, 1'b1);
    req1("err_ld_f111",  1'b0, 3'b111, 10'h004, 32'h0, 32'h0, 1'b1);
    req1("err_ld_f011",  1'b0, 3'b011, 10'h004, 32'h0, 32'h0, 1'b1);
    req1("lw_04_kept",   1'b0, 3'b010, 10'h004, 32'h0, 32'hCAFEF00D, 1'b0);
    req1("lw_00_kept",   1'b0, 3'b010, 10'h000, 32'h0, 32'h01020304, 1'b0);
    req1("lw_fc_last",   1'b0, 3'b010, 10'h0FC, 32'h0, 32'h00000077, 1'b0);
    drain();
  endtask

  task automatic test_latency3();
    req3("sw_20_l3", 1'b1, 3'b010, 8'h20, 32'hA5A50001, 32'h0, 1'b0);
    drain();
    q3.push_back({1'b0, 32'hA5A50001}); n3.push_back("lat3_first");
    q3.push_back({1'b0, 32'hA5A50001}); n3.push_back("lat3_second");
    v3 = 1'b1; we3 = 1'b0; f3 = 3'b010; a3 = 8'h20;
    tick();
    checks++;
    if ({rdy3, rv3} !== 2'b00) begin
      errors++; $display("FAIL lat3_wait1 got ready=%b valid=%b required ready=0 valid=0", rdy3, rv3);
    end
    tick();
    checks++;
    if ({rdy3, rv3} !== 2'b00) begin
      errors++; $display("FAIL lat3_wait2 got ready=%b valid=%b required ready=0 valid=0", rdy3, rv3);
    end
    tick();
    checks++;
    if ({rdy3, rv3} !== 2'b11) begin
      errors++; $display("FAIL lat3_resp got ready=%b valid=%b required ready=1 valid=1", rdy3, rv3);
    end
    tick();
    v3 = 1'b0;
    checks++;
    if ({rdy3, rv3} !== 2'b00) begin
      errors++; $display("FAIL lat3_b2b_wait got ready=%b valid=%b required ready=0 valid=0", rdy3, rv3);
    end
    tick();
    checks++;
    if ({rdy3, rv3} !== 2'b00) begin
      errors++; $display("FAIL lat3_b2b_wait2 got ready=%b valid=%b required ready=0 valid=0", rdy3, rv3);
    end
    tick();
    checks++;
    if ({rdy3, rv3} !== 2'b11) begin
      errors++; $display("FAIL lat3_b2b_resp got ready=%b valid=%b required ready=1 valid=1", rdy3, rv3);
    end
    tick();
    checks++;
    if ({rdy3, rv3} !== 2'b10) begin
      errors++; $display("FAIL lat3_idle got ready=%b valid=%b required ready=1 valid=0", rdy3, rv3);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    v3 = 1'b1; we3 = 1'b1; f3 = 3'b010; a3 = 8'h0C; wd3 = 32'h11111111;
    tick();
    v3 = 1'b0; we3 = 1'b0;
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    checks++;
    if ({rdy3, rv3} !== 2'b10) begin
      errors++; $display("FAIL rst_mid_state got ready=%b valid=%b required ready=1 valid=0", rdy3, rv3);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rv3 !== 1'b0) begin
        errors++; $display("FAIL rst_mid_dropped got valid=%b required valid=0", rv3);
      end
    end
    req3("lw_0c_after_rst", 1'b0, 3'b010, 8'h0C, 32'h0, 32'h11111111, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_load_ext();
    test_sub_word_store();
    test_errors();
    test_latency3();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
